// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the MIPS controller and md_unit
// Signals:
//   start  - request qualifier, op is sampled only when high
//   op     - 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
//   A, B   - rs / rt operands
//   busy   - operation in flight; controller stalls on (start | busy)
//   done   - one-cycle pulse after HI/LO take a result
//   hi, lo - HI/LO registers
interface md_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: fixed-latency multiply/divide unit with HI/LO registers
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous active-high reset, clears all state
//   bus   - md_unit_if slave: start/op/A/B in, busy/done/hi/lo out
// Parameters: WIDTH (>=2), MULT_CYCLES (>=1), DIV_CYCLES (>=1)
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave bus
);
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSV   = 3'd7
    } op_e;

    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d;

    // Result is formed combinationally from the latched operands; only the
    // write edge (cnt 1 -> 0) is observable, so the latency is pure delay.
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic                      is_mult, is_sdiv, a_neg, b_neg;
    logic [WIDTH-1:0]          a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    assign is_mult = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign is_sdiv = (op_q == OP_DIV);

    // Signed divide on magnitudes. The most-negative value negates to itself,
    // which as an unsigned magnitude is correct, and MIN / -1 wraps back to MIN.
    assign a_neg = is_sdiv & a_q[WIDTH-1];
    assign b_neg = is_sdiv & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

    logic finishing, can_accept, is_muldiv;

    assign finishing  = (cnt_q == CW'(1));
    // A new multiply/divide may enter on the finishing edge (back-to-back).
    assign can_accept = (cnt_q == '0) || finishing;
    assign is_muldiv  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                        (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = finishing;
        if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
        if (finishing && is_mult)
            {hi_d, lo_d} = (op_q == OP_MULT) ? prod_s : prod_u;
        // Divide by zero leaves HI/LO untouched but keeps normal timing.
        if (finishing && !is_mult && (b_q != '0)) begin
            hi_d = rem;
            lo_d = quot;
        end
        if (bus.start && can_accept && is_muldiv) begin
            op_d  = bus.op;
            a_d   = bus.A;
            b_d   = bus.B;
            cnt_d = ((bus.op == OP_MULT) || (bus.op == OP_MULTU)) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
        // Moves only in true idle: a finishing unit still reports busy.
        if (bus.start && (cnt_q == '0) && (bus.op == OP_MTHI))
            hi_d = bus.A;
        if (bus.start && (cnt_q == '0) && (bus.op == OP_MTLO))
            lo_d = bus.A;
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with a longint reference model
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] eh = '0;
    logic [W-1:0] el = '0;

    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one operation, {hi, lo}, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [63:0] prev);
        longint     sa, sb, q, r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (o)
            3'd1: p = sa * sb;
            3'd2: p = {32'b0, a} * {32'b0, b};
            3'd3: begin
                if (b == 0) p = prev;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd4: p = (b == 0) ? prev : {a % b, a / b};
            default: p = prev;
        endcase
        return p;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n, nb;
        n = (o <= 3'd2) ? MC : DC;
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        nb = 0;
        while (bus.busy && nb < 200) begin
            nb++;
            tick();
        end
        {eh, el} = ref_res(o, a, b, {eh, el});
        chk("busy_len", 64'(nb), 64'(n));
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("hi", 64'(bus.hi), 64'(eh));
        chk("lo", 64'(bus.lo), 64'(el));
        tick();
        chk("done_clear", 64'(bus.done), 64'd0);
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [W-1:0] a);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        tick();
        bus.start = 1'b0;
        if (o == 3'd5) eh = a;
        else if (o == 3'd6) el = a;
        chk("mt_busy", 64'(bus.busy), 64'd0);
        chk("mt_done", 64'(bus.done), 64'd0);
        chk("mt_hi", 64'(bus.hi), 64'(eh));
        chk("mt_lo", 64'(bus.lo), 64'(el));
    endtask

    initial begin
        int nb;
        logic seen_done;
        logic [2:0] o;
        logic [W-1:0] a, b;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.A     = '0;
        bus.B     = '0;
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        tick();

        do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi_const", 64'(bus.hi), 64'h1);
        chk("multu_lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        chk("mult_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
        do_op(3'd4, 32'd7, 32'd2);
        chk("divu_lo_const", 64'(bus.lo), 64'd3);

        do_mt(3'd6, 32'h1234);
        do_op(3'd4, 32'd99, 32'd0);
        chk("div0_lo_const", 64'(bus.lo), 64'h1234);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divmin_lo", 64'(bus.lo), 64'h8000_0000);
        chk("divmin_hi", 64'(bus.hi), 64'h0);
        do_op(3'd3, 32'd7, 32'hFFFF_FFFE);
        do_op(3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE);

        // Ignored op codes 0 and 7.
        bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'h55; tick();
        bus.op = 3'd7; tick();
        bus.start = 1'b0;
        chk("ign_busy", 64'(bus.busy), 64'd0);
        chk("ign_hi", 64'(bus.hi), 64'(eh));
        chk("ign_lo", 64'(bus.lo), 64'(el));

        // MTHI and MULTU while busy are dropped.
        bus.start = 1'b1; bus.op = 3'd1; bus.A = 32'd3; bus.B = 32'd5; tick();
        bus.op = 3'd5; bus.A = 32'hAAAA; tick();
        bus.op = 3'd2; bus.A = 32'd7; bus.B = 32'd7; tick();
        bus.start = 1'b0;
        nb = 2;
        while (bus.busy && nb < 200) begin
            nb++;
            tick();
        end
        eh = 32'd0; el = 32'd15;
        chk("ign_busy_len", 64'(nb), 64'(MC));
        chk("ign_busy_done", 64'(bus.done), 64'd1);
        chk("ign_busy_hi", 64'(bus.hi), 64'(eh));
        chk("ign_busy_lo", 64'(bus.lo), 64'(el));
        tick();
        chk("ign_busy_after", 64'(bus.busy), 64'd0);

        // Back-to-back: DIVU accepted on the MULTU finishing edge.
        bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'h1234_5678; bus.B = 32'h9ABC; tick();
        bus.start = 1'b0;
        for (int i = 0; i < MC - 1; i++) tick();
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'd1000; bus.B = 32'd7; tick();
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        {eh, el} = ref_res(3'd2, 32'h1234_5678, 32'h9ABC, {eh, el});
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        chk("b2b_done", 64'(bus.done), 64'd1);
        chk("b2b_hi", 64'(bus.hi), 64'(eh));
        chk("b2b_lo", 64'(bus.lo), 64'(el));
        nb = 0;
        while (bus.busy && nb < 200) begin
            nb++;
            tick();
        end
        {eh, el} = ref_res(3'd4, 32'd1000, 32'd7, {eh, el});
        chk("b2b_len2", 64'(nb), 64'(DC));
        chk("b2b_done2", 64'(bus.done), 64'd1);
        chk("b2b_hi2", 64'(bus.hi), 64'(eh));
        chk("b2b_lo2", 64'(bus.lo), 64'(el));
        tick();

        // Reset mid-run clears immediately and discards the result.
        bus.start = 1'b1; bus.op = 3'd1; bus.A = 32'h1234_5678; bus.B = 32'd9; tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_hi", 64'(bus.hi), 64'd0);
        chk("arst_lo", 64'(bus.lo), 64'd0);
        #2;
        reset = 1'b0;
        eh = '0; el = '0;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        chk("arst_no_done", 64'(seen_done), 64'd0);
        chk("arst_hi_after", 64'(bus.hi), 64'd0);
        chk("arst_lo_after", 64'(bus.lo), 64'd0);

        // Randomized operations against the model.
        for (int k = 0; k < 24; k++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            if (k % 3 == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
            if (k % 6 == 0) b = '0;
            if (k % 7 == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (o >= 3'd5) do_mt(o, a);
            else do_op(o, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers, the next-generation arithmetic block for the MIPS datapath beside `alu`. It executes MULT/MULTU/DIV/DIVU over a fixed, parameter-set latency and handles MTHI/MTLO writes. During that latency it raises `busy` so the controller can stall dependent HI/LO instructions. Results are held in internal HI/LO registers that are always visible on the outputs.

## Interface
- `WIDTH`, 32, operand width and HI/LO width; must be at least 2.
- `MULT_CYCLES`, 5, cycles from accepted multiply to result; must be at least 1.
- `DIV_CYCLES`, 10, cycles from accepted divide to result; must be at least 1.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request qualifier; `op` is sampled only when `start`=1.
- `op`  in  3  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (ignored).
- `A`  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- `B`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  registered; high while an operation is in flight.
- `done`  out  1  registered one-cycle pulse on the cycle after HI/LO take a result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- State is IDLE or RUN, implemented as a down-counter `cnt`; `busy` = (`cnt` != 0).
- **Accept.** In IDLE, at an edge with `start`=1 and `op` in 1..4:
  - latch `op`, `A`, `B`;
  - load `cnt` with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
- **Run.** Each edge in RUN decrements `cnt`. At the edge where `cnt` goes 1→0, the latched result is written to HI/LO and `done` is set for one cycle.
- **Multiply.**
  - MULT: signed WIDTH×WIDTH → 2·WIDTH product; HI = upper half, LO = lower half.
  - MULTU: the same, unsigned.
- **Divide.**
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - Divisor 0 (DIV or DIVU): HI/LO keep their previous values; `busy` and `done` still follow the normal timing.
  - DIV of the most-negative value by −1: LO = most-negative value (wrap), HI = 0.
- **MTHI / MTLO.** In IDLE with `start`=1, MTHI writes HI ← A (MTLO writes LO ← A) at the same edge. No `busy`, no `done`.
- **Ignored requests.**
  - Any `start` while `busy`=1 is ignored, including MTHI/MTLO. The controller must stall on (`start` | `busy`).
  - `op` = 0 or 7 with `start`=1 is ignored.
- The result may be computed combinationally from the latched operands or iteratively. Only the HI/LO update edge is observable, and it is fixed by the parameter.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `cnt`=0, latched operands 0.
- Accept at edge k with latency N:
  - `busy`=1 after edges k .. k+N−1;
  - HI/LO update and `busy`→0 at edge k+N;
  - `done`=1 for the single cycle after edge k+N.
- N=1: `busy` is high for exactly one cycle.
- Back-to-back: a new `start` is accepted at edge k+N itself, because `cnt`=1 before that edge and the unit is finishing. The new operation loads `cnt` at that edge, `busy` stays 1, and `done` still pulses for the finished operation.
- MTHI/MTLO at edge k: the new value appears on `hi`/`lo` after edge k.
- Reset asserted mid-RUN: the pending result is discarded and all outputs clear immediately, with no waiting for a clock edge. The first accept is possible at the first edge after deassertion.
- `A`/`B` may change after the accept edge without affecting the result.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF, B=2 (defaults) → `busy`=1 for exactly 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE, with `done` pulsing once.
- MULT A=0xFFFFFFFF, B=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE after 5 cycles.
- Divide sequence:
  - DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - then DIVU A=7, B=2 → lo=3, hi=1.
- MTLO A=0x1234 → lo=0x1234 on the next edge, `busy` stays 0. Then DIVU B=0 → after 10 cycles lo stays 0x1234 and `done` pulses.
- MULT started, then MTHI A=0xAAAA and MULTU issued while `busy` → both ignored; only the first result lands.
- MULT started, then `reset` pulsed at cycle 3 → outputs clear immediately; no `done`, and hi/lo remain 0 after release.
